// File: rtl/paddle_motion_unit.sv
// Paddle motion for one player: button sync and debounce, direction select,
// move-rate divider and clamped Y position.
module paddle_motion_unit #(
  parameter int unsigned DEBOUNCE_WIDTH_IN_CLOCKS       = 50,
  parameter int unsigned POSITION_CHANGE_FREQ_IN_CLOCKS = 10,
  parameter int unsigned TOTAL_HEIGHT                   = 480,
  parameter int unsigned PADDLE_HEIGHT                  = 80,
  parameter int unsigned BORDER_PIXEL_WIDTH             = 8,
  parameter int unsigned INITIAL_PADDLE_Y               = 200,
  parameter int unsigned HEIGHT_COUNTER_SIZE            = $clog2(TOTAL_HEIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         button_up,
  input  logic                         button_down,
  output logic [HEIGHT_COUNTER_SIZE:0] paddle_pos,
  output logic                         moving,
  output logic                         at_top,
  output logic                         at_bottom
);

  localparam int unsigned POS_W   = HEIGHT_COUNTER_SIZE + 1;
  localparam int unsigned MIN_Y   = BORDER_PIXEL_WIDTH;
  localparam int          MAX_Y_S = int'(TOTAL_HEIGHT) - int'(BORDER_PIXEL_WIDTH)
                                    - int'(PADDLE_HEIGHT);
  localparam int unsigned MAX_Y   = (MAX_Y_S < 0) ? 0 : unsigned'(MAX_Y_S);
  localparam int unsigned DB_W    = ($clog2(DEBOUNCE_WIDTH_IN_CLOCKS + 1) < 1) ? 1
                                    : $clog2(DEBOUNCE_WIDTH_IN_CLOCKS + 1);
  localparam int unsigned RATE_W  = ($clog2(POSITION_CHANGE_FREQ_IN_CLOCKS + 1) < 1) ? 1
                                    : $clog2(POSITION_CHANGE_FREQ_IN_CLOCKS + 1);

  if (MAX_Y_S < int'(MIN_Y)) begin : g_chk_range
    $error("paddle_motion_unit: MAX_Y below MIN_Y");
  end
  if (INITIAL_PADDLE_Y < MIN_Y || INITIAL_PADDLE_Y > MAX_Y) begin : g_chk_init
    $error("paddle_motion_unit: INITIAL_PADDLE_Y outside [MIN_Y, MAX_Y]");
  end
  if (DEBOUNCE_WIDTH_IN_CLOCKS < 1 || POSITION_CHANGE_FREQ_IN_CLOCKS < 1) begin : g_chk_rate
    $error("paddle_motion_unit: rate parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  logic [1:0] btn_raw;
  logic [1:0] sync_meta;
  logic [1:0] sync_q;
  logic [1:0] stable;

  assign btn_raw = {button_down, button_up};

  // Two-flop synchronizer, bit 0 = up, bit 1 = down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // A new level is accepted only after DEBOUNCE_WIDTH_IN_CLOCKS consecutive mismatches
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic            stable_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (sync_q[b] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DEBOUNCE_WIDTH_IN_CLOCKS - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync_q[b];
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end

    assign stable[b] = stable_q;
  end

  dir_e              dir_q;
  dir_e              dir_c;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rate_c;
  logic [POS_W-1:0]  pos_c;

  // Direction select, rate divider and clamped step
  always_comb begin
    dir_c  = DIR_IDLE;
    rate_c = '0;
    pos_c  = paddle_pos;

    case (stable)
      2'b01:   dir_c = DIR_UP;
      2'b10:   dir_c = DIR_DOWN;
      default: dir_c = DIR_IDLE;
    endcase

    if (dir_c == dir_q && dir_q != DIR_IDLE) begin
      if (rate_q == RATE_W'(POSITION_CHANGE_FREQ_IN_CLOCKS - 1)) begin
        rate_c = '0;
        if (dir_q == DIR_UP && paddle_pos > POS_W'(MIN_Y)) begin
          pos_c = paddle_pos - POS_W'(1);
        end else if (dir_q == DIR_DOWN && paddle_pos < POS_W'(MAX_Y)) begin
          pos_c = paddle_pos + POS_W'(1);
        end
      end else begin
        rate_c = rate_q + RATE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= DIR_IDLE;
      rate_q     <= '0;
      paddle_pos <= POS_W'(INITIAL_PADDLE_Y);
      moving     <= 1'b0;
      at_top     <= (INITIAL_PADDLE_Y == MIN_Y);
      at_bottom  <= (INITIAL_PADDLE_Y == MAX_Y);
    end else begin
      dir_q      <= dir_c;
      rate_q     <= rate_c;
      paddle_pos <= pos_c;
      moving     <= (dir_c != DIR_IDLE);
      at_top     <= (pos_c == POS_W'(MIN_Y));
      at_bottom  <= (pos_c == POS_W'(MAX_Y));
    end
  end

endmodule

// File: tb/tb_paddle_motion_unit.sv
// Directed bench for paddle_motion_unit with D=4, N=3, height 40, paddle 10,
// border 2, initial 15 (MIN_Y=2, MAX_Y=28).
module tb_paddle_motion_unit;

  localparam int unsigned HCS   = $clog2(40 + 1);
  localparam int unsigned POS_W = HCS + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             button_up = 1'b0;
  logic             button_down = 1'b0;
  logic [POS_W-1:0] paddle_pos;
  logic             moving;
  logic             at_top;
  logic             at_bottom;

  int checks = 0;
  int errors = 0;

  paddle_motion_unit #(
    .DEBOUNCE_WIDTH_IN_CLOCKS      (4),
    .POSITION_CHANGE_FREQ_IN_CLOCKS(3),
    .TOTAL_HEIGHT                  (40),
    .PADDLE_HEIGHT                 (10),
    .BORDER_PIXEL_WIDTH            (2),
    .INITIAL_PADDLE_Y              (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_up  (button_up),
    .button_down(button_down),
    .paddle_pos (paddle_pos),
    .moving     (moving),
    .at_top     (at_top),
    .at_bottom  (at_bottom)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    button_up   = 1'b0;
    button_down = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (paddle_pos !== POS_W'(15)) begin
      errors++; $display("FAIL reset_pos: got %0d expected 15", paddle_pos);
    end
    checks++;
    if ({moving, at_top, at_bottom} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {moving, at_top, at_bottom});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    button_down = 1'b1;
    tick(); tick(); tick();
    button_down = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (moving !== 1'b0 || paddle_pos !== POS_W'(15)) begin
        errors++;
        $display("FAIL glitch cyc%0d: moving=%b pos=%0d expected moving=0 pos=15", i, moving, paddle_pos);
      end
    end
  endtask

  task automatic test_hold_down();
    int exp_pos;
    do_reset();
    button_down = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp_pos = (i < 10) ? 15 : 16 + (i - 10) / 3;
      if (exp_pos > 28) exp_pos = 28;
      checks++;
      if (paddle_pos !== POS_W'(exp_pos) || at_bottom !== (exp_pos == 28) || at_top !== 1'b0) begin
        errors++;
        $display("FAIL hold_down cyc%0d: pos=%0d bot=%b top=%b expected pos=%0d bot=%b top=0",
                 i, paddle_pos, at_bottom, at_top, exp_pos, (exp_pos == 28));
      end
      checks++;
      if (moving !== (i >= 7)) begin
        errors++;
        $display("FAIL hold_down_moving cyc%0d: got %b expected %b", i, moving, (i >= 7));
      end
    end
    button_down = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (moving !== (i < 7) || paddle_pos !== POS_W'(28)) begin
        errors++;
        $display("FAIL release_down cyc%0d: moving=%b pos=%0d expected moving=%b pos=28",
                 i, moving, paddle_pos, (i < 7));
      end
    end
  endtask

  task automatic test_hold_up();
    int exp_pos;
    do_reset();
    button_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp_pos = (i < 10) ? 15 : 14 - (i - 10) / 3;
      if (exp_pos < 2) exp_pos = 2;
      checks++;
      if (paddle_pos !== POS_W'(exp_pos) || at_top !== (exp_pos == 2) || at_bottom !== 1'b0) begin
        errors++;
        $display("FAIL hold_up cyc%0d: pos=%0d top=%b bot=%b expected pos=%0d top=%b bot=0",
                 i, paddle_pos, at_top, at_bottom, exp_pos, (exp_pos == 2));
      end
    end
    button_up = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    checks++;
    if (moving !== 1'b0 || paddle_pos !== POS_W'(2)) begin
      errors++;
      $display("FAIL release_up: moving=%b pos=%0d expected moving=0 pos=2", moving, paddle_pos);
    end
  endtask

  task automatic test_both_buttons();
    do_reset();
    button_up   = 1'b1;
    button_down = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (moving !== 1'b0 || paddle_pos !== POS_W'(15)) begin
        errors++;
        $display("FAIL both cyc%0d: moving=%b pos=%0d expected moving=0 pos=15", i, moving, paddle_pos);
      end
    end
    button_down = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (moving !== (i >= 7) || paddle_pos !== POS_W'((i >= 10) ? 14 : 15)) begin
        errors++;
        $display("FAIL both_release cyc%0d: moving=%b pos=%0d expected moving=%b pos=%0d",
                 i, moving, paddle_pos, (i >= 7), (i >= 10) ? 14 : 15);
      end
    end
    button_up = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
  endtask

  task automatic test_reversal();
    int exp_pos;
    do_reset();
    button_up = 1'b1;
    for (int i = 1; i <= 13; i++) tick();
    checks++;
    if (paddle_pos !== POS_W'(13)) begin
      errors++; $display("FAIL reversal_pre: got %0d expected 13", paddle_pos);
    end
    button_up   = 1'b0;
    button_down = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp_pos = (j < 3) ? 13 : (j < 6) ? 12 : (j < 10) ? 11 : 12;
      checks++;
      if (paddle_pos !== POS_W'(exp_pos) || moving !== 1'b1) begin
        errors++;
        $display("FAIL reversal cyc%0d: pos=%0d moving=%b expected pos=%0d moving=1",
                 j, paddle_pos, moving, exp_pos);
      end
    end
    button_down = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
  endtask

  task automatic test_rst_mid_move();
    do_reset();
    button_down = 1'b1;
    for (int i = 1; i <= 28; i++) tick();
    checks++;
    if (paddle_pos !== POS_W'(22) || moving !== 1'b1) begin
      errors++;
      $display("FAIL mid_move_pre: pos=%0d moving=%b expected pos=22 moving=1", paddle_pos, moving);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (paddle_pos !== POS_W'(15) || moving !== 1'b0) begin
      errors++;
      $display("FAIL mid_move_rst: pos=%0d moving=%b expected pos=15 moving=0", paddle_pos, moving);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      checks++;
      if (paddle_pos !== POS_W'((i < 10) ? 15 : 16 + (i - 10) / 3)) begin
        errors++;
        $display("FAIL mid_move_resume cyc%0d: got %0d expected %0d",
                 i, paddle_pos, (i < 10) ? 15 : 16 + (i - 10) / 3);
      end
    end
    button_down = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold_down();
    test_hold_up();
    test_both_buttons();
    test_reversal();
    test_rst_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
